// File: rtl/compare_select_pkg.sv
// Shared stage record and tree sizing helpers for the compare/select pipe.
// Records are sized for the widest legal element and index.
package compare_select_pkg;

  localparam int MAX_W   = 64;
  localparam int MAX_PTR = 6;

  typedef struct packed {
    logic               valid;
    logic               eligible;
    logic [MAX_PTR-1:0] ptr;
    logic [MAX_W-1:0]   value;
  } stage_rec_t;

  function automatic int level_count(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int nodes_at(input int n, input int k);
    int c;
    c = n;
    for (int i = 0; i < k; i++) c = (c + 1) / 2;
    return c;
  endfunction

endpackage

// File: rtl/compare_select_node.sv
// Two-input eligible max; equal values resolve to the lower index.
// COMPARE_SELECT_SIGNED_EN selects two's-complement comparison.
module compare_select_node
  import compare_select_pkg::*;
(
  input  stage_rec_t a,
  input  stage_rec_t b,
  output stage_rec_t y
);

  logic gt;
  logic eq;
  logic a_wins;

  // Pick the eligible larger value, lowest index on a tie.
  always_comb begin
`ifdef COMPARE_SELECT_SIGNED_EN
    gt = $signed(a.value) > $signed(b.value);
`else
    gt = a.value > b.value;
`endif
    eq = a.value == b.value;
    a_wins = a.eligible &
             (~b.eligible | gt | (eq & (a.ptr <= b.ptr)));
    y = '0;
    if (a_wins) y = a;
    else if (b.eligible) y = b;
    y.valid = a.valid & b.valid;
  end

endmodule

// File: rtl/pipelined_compare_select.sv
// Pipelined eligible-max tree, one register stage per level.
// COMPARE_SELECT_SIGNED_EN: compare elements as signed values.
module pipelined_compare_select
  import compare_select_pkg::*;
#(
  parameter int NUM_ELEMENTS  = 8,
  parameter int ELEMENT_WIDTH = 8,
  parameter int PTR_WIDTH     = $clog2(NUM_ELEMENTS)
) (
  input  logic                                  clk_in,
  input  logic                                  reset_n_in,
  input  logic                                  in_valid_in,
  output logic                                  in_ready_out,
  input  logic [NUM_ELEMENTS-1:0]               condition_in,
  input  logic [NUM_ELEMENTS*ELEMENT_WIDTH-1:0] elements_in,
  output logic                                  out_valid_out,
  input  logic                                  out_ready_in,
  output logic                                  found_out,
  output logic [PTR_WIDTH-1:0]                  selected_ptr_out,
  output logic [ELEMENT_WIDTH-1:0]              selected_value_out
);

  localparam int N = NUM_ELEMENTS;
  localparam int W = ELEMENT_WIDTH;
  localparam int L = level_count(N);

  stage_rec_t lv_in [L][N];
  stage_rec_t nx    [L][N];
  stage_rec_t st    [1:L][N];
  logic [L:1] ld;
  logic       acc;
  logic       unused_hi;

  function automatic logic [MAX_W-1:0] extend(
    input logic [W-1:0] e
  );
    logic [MAX_W-1:0] r;
`ifdef COMPARE_SELECT_SIGNED_EN
    r = {MAX_W{e[W-1]}};
`else
    r = '0;
`endif
    r[W-1:0] = e;
    return r;
  endfunction

  // Stage loads when it or any later stage has room.
  always_comb begin
    ld  = '0;
    acc = out_ready_in;
    for (int k = L; k >= 1; k--) begin
      acc   = acc | ~st[k][0].valid;
      ld[k] = acc;
    end
  end

  assign in_ready_out = ld[1];

  // Level inputs: leaf records, then the stage registers.
  always_comb begin
    for (int k = 0; k < L; k++)
      for (int j = 0; j < N; j++) lv_in[k][j] = '0;
    for (int i = 0; i < N; i++) begin
      lv_in[0][i].valid = in_valid_in;
      if (in_valid_in && condition_in[i]) begin
        lv_in[0][i].eligible = 1'b1;
        lv_in[0][i].ptr      = MAX_PTR'(i);
        lv_in[0][i].value    = extend(elements_in[i*W +: W]);
      end
    end
    for (int k = 1; k < L; k++)
      for (int j = 0; j < N; j++) lv_in[k][j] = st[k][j];
  end

  for (genvar k = 0; k < L; k++) begin : g_lvl
    localparam int NK = nodes_at(N, k);
    localparam int H  = (NK + 1) / 2;
    for (genvar j = 0; j < N; j++) begin : g_slot
      if (j + H < NK) begin : g_pair
        compare_select_node u_node (
          .a (lv_in[k][j]),
          .b (lv_in[k][j+H]),
          .y (nx[k][j])
        );
      end else if (j < H) begin : g_pass
        assign nx[k][j] = lv_in[k][j];
      end else begin : g_zero
        assign nx[k][j] = '0;
      end
    end
  end

  // Stage registers advance together under the load chain.
  always_ff @(posedge clk_in or negedge reset_n_in) begin
    if (!reset_n_in) begin
      for (int k = 1; k <= L; k++)
        for (int j = 0; j < N; j++) st[k][j] <= '0;
    end else begin
      for (int k = 1; k <= L; k++)
        if (ld[k])
          for (int j = 0; j < N; j++) st[k][j] <= nx[k-1][j];
    end
  end

  assign out_valid_out      = st[L][0].valid;
  assign found_out          = st[L][0].eligible;
  assign selected_ptr_out   = st[L][0].ptr[PTR_WIDTH-1:0];
  assign selected_value_out = st[L][0].value[W-1:0];
  assign unused_hi          = ^{st[L][0].ptr, st[L][0].value};

endmodule

// File: tb/tb_pipelined_compare_select.sv
// Scoreboard bench for pipelined_compare_select (N=8 and N=5).
// Expected results are queued at request transfer.
module tb_pipelined_compare_select;

  localparam int N = 8;
  localparam int W = 8;
  localparam int L = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic           in_valid, in_ready, out_valid, out_ready, found;
  logic [N-1:0]   cond;
  logic [N*W-1:0] elems;
  logic [2:0]     ptr;
  logic [7:0]     val;

  pipelined_compare_select #(.NUM_ELEMENTS(8), .ELEMENT_WIDTH(8)) dut (
    .clk_in(clk), .reset_n_in(rst_n),
    .in_valid_in(in_valid), .in_ready_out(in_ready),
    .condition_in(cond), .elements_in(elems),
    .out_valid_out(out_valid), .out_ready_in(out_ready),
    .found_out(found), .selected_ptr_out(ptr),
    .selected_value_out(val)
  );

  logic       v5, r5, ov5, f5;
  logic [4:0] c5;
  logic [39:0] e5;
  logic [2:0] p5;
  logic [7:0] val5;

  pipelined_compare_select #(.NUM_ELEMENTS(5), .ELEMENT_WIDTH(8)) dut5 (
    .clk_in(clk), .reset_n_in(rst_n),
    .in_valid_in(v5), .in_ready_out(r5),
    .condition_in(c5), .elements_in(e5),
    .out_valid_out(ov5), .out_ready_in(1'b1),
    .found_out(f5), .selected_ptr_out(p5),
    .selected_value_out(val5)
  );

  typedef struct packed {
    logic       found;
    logic [2:0] ptr;
    logic [7:0] val;
  } res_t;

  typedef struct {
    logic [7:0]  c;
    logic [63:0] e;
    res_t        x;
  } vec_t;

  typedef struct {
    logic [4:0]  c;
    logic [39:0] e;
    res_t        x;
  } vec5_t;

  vec_t  tbl [10];
  vec5_t tbl5 [4];
  res_t  exp_q [$];
  int    out_cyc [$];
  res_t  cur_exp, pe;
  int    errors = 0;
  int    checks = 0;
  int    n_out = 0;
  int    cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] pack8(
    input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    return {b7, b6, b5, b4, b3, b2, b1, b0};
  endfunction

  // Reference: linear scan, strict greater keeps the lowest index.
  function automatic res_t model(input logic [7:0] c,
                                 input logic [63:0] e);
    res_t r;
    logic signed [8:0] best, v;
    logic [7:0] b;
    r = '0;
    best = '0;
    for (int i = 0; i < N; i++) begin
      b = e[i*8 +: 8];
`ifdef COMPARE_SELECT_SIGNED_EN
      v = {b[7], b};
`else
      v = {1'b0, b};
`endif
      if (c[i] && (!r.found || v > best)) begin
        r.found = 1'b1;
        r.ptr = 3'(i);
        r.val = b;
        best = v;
      end
    end
    return r;
  endfunction

  // Scoreboard: pop on output transfer, push on input transfer.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out_valid && out_ready) begin
        n_out++;
        out_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got %0h expected none",
                   {found, ptr, val});
        end else begin
          pe = exp_q.pop_front();
          check("result", {20'd0, found, ptr, val}, {20'd0, pe});
        end
      end
      if (in_valid && in_ready) exp_q.push_back(cur_exp);
    end
  end

  task automatic drive(input logic [7:0] c, input logic [63:0] e,
                       input res_t x);
    cond = c;
    elems = e;
    cur_exp = x;
    in_valid = 1'b1;
  endtask

  task automatic drive_rand();
    logic [7:0]  rc;
    logic [63:0] re;
    rc = 8'($urandom);
    if ($urandom_range(0, 3) == 0) rc = 8'h00;
    re = {$urandom, $urandom};
    if ($urandom_range(0, 1) == 0) re = re & 64'h0303030303030303;
    drive(rc, re, model(rc, re));
  endtask

  task automatic drain(input string name);
    int k;
    k = 0;
    while ((exp_q.size() != 0 || out_valid) && k < 60) begin
      @(posedge clk); #1;
      k++;
    end
    check(name, exp_q.size(), 0);
  endtask

  int   acc_cnt, sent, base, k;
  logic took;
  logic [11:0] held;

  initial begin
    tbl[0] = '{8'hFF, pack8(3, 9, 1, 9, 0, 2, 7, 4), '{1'b1, 3'd1, 8'd9}};
    tbl[1] = '{8'h00, pack8(5, 5, 5, 5, 5, 5, 5, 5), '{1'b0, 3'd0, 8'd0}};
    tbl[2] = '{8'h01, pack8(0, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F, 8'h7F,
                           8'h7F), '{1'b1, 3'd0, 8'd0}};
    tbl[3] = '{8'h80, pack8(8'h70, 8'h70, 8'h70, 8'h70, 8'h70, 8'h70,
                           8'h70, 5), '{1'b1, 3'd7, 8'd5}};
    tbl[4] = '{8'hFF, {8{8'h11}}, '{1'b1, 3'd0, 8'h11}};
    tbl[5] = '{8'hAA, pack8(8'h7F, 2, 8'h7E, 6, 0, 6, 1, 3),
               '{1'b1, 3'd3, 8'd6}};
    tbl[6] = '{8'h55, pack8(0, 10, 20, 30, 40, 50, 60, 70),
               '{1'b1, 3'd6, 8'd60}};
    tbl[7] = '{8'hFF, pack8(7, 6, 5, 4, 3, 2, 1, 0), '{1'b1, 3'd0, 8'd7}};
    tbl[8] = '{8'h60, pack8(1, 1, 1, 1, 1, 8'h7F, 8'h7F, 1),
               '{1'b1, 3'd5, 8'h7F}};
`ifdef COMPARE_SELECT_SIGNED_EN
    tbl[9] = '{8'h03, pack8(8'h80, 8'h01, 0, 0, 0, 0, 0, 0),
               '{1'b1, 3'd1, 8'h01}};
`else
    tbl[9] = '{8'h03, pack8(8'h80, 8'h01, 0, 0, 0, 0, 0, 0),
               '{1'b1, 3'd0, 8'h80}};
`endif
    tbl5[0] = '{5'b10000, 40'd0, '{1'b1, 3'd4, 8'd0}};
    tbl5[1] = '{5'b00100, {8'd9, 8'd9, 8'd3, 8'd9, 8'd9},
                '{1'b1, 3'd2, 8'd3}};
    tbl5[2] = '{5'b00000, {8'd9, 8'd8, 8'd7, 8'd6, 8'd5},
                '{1'b0, 3'd0, 8'd0}};
    tbl5[3] = '{5'b11111, {8'd5, 8'd2, 8'd5, 8'd5, 8'd1},
                '{1'b1, 3'd1, 8'd5}};

    rst_n = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    cond = '0;
    elems = '0;
    cur_exp = '0;
    v5 = 1'b0;
    c5 = '0;
    e5 = '0;

    repeat (3) @(posedge clk);
    #1;
    check("reset_out_valid", out_valid, 0);
    check("reset_found", found, 0);
    check("reset_ptr", ptr, 0);
    check("reset_value", val, 0);
    rst_n = 1'b1;
    #1;
    check("reset_in_ready", in_ready, 1);

    // Single request latency.
    @(posedge clk); #1;
    drive(tbl[0].c, tbl[0].e, tbl[0].x);
    k = 0;
    do begin
      @(posedge clk); #1;
      in_valid = 1'b0;
      k++;
    end while (!out_valid && k < 20);
    check("latency", k, L);
    drain("drain_latency");

    // Back-to-back table vectors.
    out_cyc.delete();
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      drive(tbl[i].c, tbl[i].e, tbl[i].x);
      #1;
      check("stream_ready", in_ready, 1);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("drain_stream");
    check("stream_count", out_cyc.size(), 10);
    if (out_cyc.size() == 10)
      check("stream_consecutive", out_cyc[9] - out_cyc[0], 9);

    // Output stall for 6 cycles while streaming.
    out_ready = 1'b0;
    acc_cnt = 0;
    took = 1'b0;
    base = n_out;
    held = '0;
    for (int c = 0; c < 6; c++) begin
      @(posedge clk); #1;
      if (c == 0 || took) drive_rand();
      #1;
      took = in_valid & in_ready;
      if (took) acc_cnt++;
      if (c == 3) begin
        check("stall_valid", out_valid, 1);
        held = {found, ptr, val};
      end
      if (c > 3)
        check("stall_hold", {out_valid, found, ptr, val}, {1'b1, held});
    end
    check("stall_accepts", acc_cnt, 3);
    check("stall_ready_low", in_ready, 0);
    out_ready = 1'b1;
    sent = 0;
    for (int c = 0; c < 6; c++) begin
      if (c > 0) begin
        @(posedge clk); #1;
      end
      if (took) begin
        if (sent < 4) begin
          drive_rand();
          sent++;
        end else begin
          in_valid = 1'b0;
        end
      end
      #1;
      if (c == 0) check("release_ready", in_ready, 1);
      took = in_valid & in_ready;
      if (took) acc_cnt++;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    drain("drain_stall");
    check("stall_total", acc_cnt, 8);
    check("stall_no_loss", n_out - base, acc_cnt);

    // Reset with two requests in flight.
    @(posedge clk); #1;
    drive(tbl[0].c, tbl[0].e, tbl[0].x);
    @(posedge clk); #1;
    drive(tbl[6].c, tbl[6].e, tbl[6].x);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #2;
    check("pre_reset_valid", out_valid, 1);
    rst_n = 1'b0;
    #1;
    check("mid_reset_valid", out_valid, 0);
    check("mid_reset_found", found, 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;
    check("post_reset_ready", in_ready, 1);
    base = n_out;
    repeat (10) @(posedge clk);
    #1;
    check("no_stale", n_out - base, 0);

    // Random traffic with random back-pressure.
    took = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(posedge clk); #1;
      out_ready = ($urandom_range(0, 9) < 7);
      if (took || !in_valid) begin
        if ($urandom_range(0, 4) != 0) drive_rand();
        else in_valid = 1'b0;
      end
      #1;
      took = in_valid & in_ready;
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    out_ready = 1'b1;
    drain("drain_random");

    // Five-element tree: odd pass-through cases.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      v5 = 1'b1;
      c5 = tbl5[i].c;
      e5 = tbl5[i].e;
      @(posedge clk); #1;
      v5 = 1'b0;
      k = 0;
      while (!ov5 && k < 10) begin
        @(posedge clk); #1;
        k++;
      end
      check("n5_valid", ov5, 1);
      check("n5_result", {20'd0, f5, p5, val5}, {20'd0, tbl5[i].x});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pipelined_compare_select.md
PIPELINED_COMPARE_SELECT -- requirements
Module: pipelined_compare_select

Interface
REQ-001 Parameter NUM_ELEMENTS, default 8: number of candidate elements; legal range 2..64, power of two not required.
REQ-002 Parameter ELEMENT_WIDTH, default 8: width of one element value in bits; legal range 1..64.
REQ-003 Parameter PTR_WIDTH, default $clog2(NUM_ELEMENTS): width of the selected index.
REQ-004 clk_in  input  1  single clock; all state changes on its rising edge.
REQ-005 reset_n_in  input  1  reset, asynchronous assert, active-low.
REQ-006 in_valid_in  input  1  a request is present on condition_in / elements_in.
REQ-007 in_ready_out  output  1  the block accepts the request this cycle.
REQ-008 condition_in  input  NUM_ELEMENTS  per-element eligibility mask.
REQ-009 elements_in  input  NUM_ELEMENTS*ELEMENT_WIDTH  packed values; element i occupies bits [(i+1)*ELEMENT_WIDTH-1 : i*ELEMENT_WIDTH].
REQ-010 out_valid_out  output  1  a result is presented.
REQ-011 out_ready_in  input  1  the consumer takes the result this cycle.
REQ-012 found_out  output  1  at least one condition bit was set in the request.
REQ-013 selected_ptr_out  output  PTR_WIDTH  index of the winning element.
REQ-014 selected_value_out  output  ELEMENT_WIDTH  value of the winning element.

Function
REQ-015 A request transfers when in_valid_in && in_ready_out. A result transfers when out_valid_out && out_ready_in.
REQ-016 Winner = the eligible element (condition bit 1) with the maximum value; ties go to the lowest index.
REQ-017 Ineligible elements never win: the 8'h00 value of an eligible element beats any ineligible element.
REQ-018 No bit of condition_in set -> found_out=0, selected_ptr_out=0, selected_value_out=0.
REQ-019 Reduction is a binary tree of L = $clog2(NUM_ELEMENTS) levels. Level k pairs node j with node j + ceil(n_k/2). An unpaired odd node passes through unchanged with its eligibility bit.
REQ-020 Each tree level is followed by one register stage holding a valid bit, eligibility, index and value. Latency from request transfer to out_valid_out is exactly L cycles when unstalled.
REQ-021 Stage k loads when its valid bit is 0 or stage k+1 loads in the same cycle (bubble collapse). The output stage loads when empty or out_ready_in=1.
REQ-022 in_ready_out equals the load condition of stage 1 and is combinational from out_ready_in only through the stage-valid chain. No combinational path exists from in_valid_in to in_ready_out.
REQ-023 Full throughput: one request accepted per cycle while out_ready_in=1.
REQ-024 When out_valid_out=1 and out_ready_in=0, all outputs hold stable until transfer.
REQ-025 When all stages are full and out_ready_in=0, in_ready_out=0 and no stage changes.
REQ-026 Simultaneous output transfer and input acceptance with a full pipe advances every stage by one and loses no result.
REQ-027 Results leave in request order; at most L results are in flight.

Reset
REQ-028 While reset_n_in=0, all stage valid bits clear immediately, discarding in-flight requests.
REQ-029 During reset, out_valid_out=0, found_out=0, selected_ptr_out=0, selected_value_out=0, and in_ready_out=1 as soon as reset releases.
REQ-030 Datapath registers other than the valid bits are reset to 0.

Configuration
REQ-031 Macro COMPARE_SELECT_SIGNED_EN defined: element values compare as two's-complement signed; the tie rule is unchanged.
REQ-032 Macro COMPARE_SELECT_SIGNED_EN undefined: element values compare as unsigned.

Structure
REQ-033 Shared package compare_select_pkg holds the stage record typedef (valid, eligible, ptr, value) and the function computing the tree level count.
REQ-034 One sub-module, compare_select_node, implements the two-input eligible-max with lowest-index tie-break. It is instantiated per node per level by generate loops.

Verification
REQ-035 Scenario: N=8, W=8, cond=8'hFF, values 3,9,1,9,0,2,7,4 -> after 3 cycles ptr=1, value=9, found=1.
REQ-036 Scenario: cond=8'h00 with any values -> found=0, ptr=0, value=0.
REQ-037 Scenario: N=5, cond=5'b10000, values all 0 except element 4=0 -> ptr=4, found=1 (odd pass-through and eligible-zero rule).
REQ-038 Scenario: 10 back-to-back requests with out_ready_in=1 -> 10 results on consecutive cycles, in order.
REQ-039 Scenario: out_ready_in=0 for 6 cycles while streaming -> in_ready_out drops after 3 accepts, outputs hold stable, no loss or duplication after release.
REQ-040 Scenario: reset asserted mid-stream with 2 in flight -> out_valid_out=0 immediately, no stale result after release. With COMPARE_SELECT_SIGNED_EN defined, values 8'h80 and 8'h01 both eligible -> ptr of 8'h01.
